// File: rtl/spm_serial_driver.sv
// Operand/result sequencer for the spm serial-parallel multiplier: holds x in parallel,
// streams sign-extended y LSB-first and gathers the serial product. Optional: SPM_DRV_SELFCHECK_EN.
module spm_serial_driver #(
  parameter int N     = 32,
  parameter int P_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic [N-1:0]   spm_x,
  output logic           spm_y,
  output logic           spm_clr,
  input  logic           spm_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy
`ifdef SPM_DRV_SELFCHECK_EN
  ,
  output logic           err
`endif
);

  localparam int CW = $clog2(2*N + P_LAT + 1);
  localparam logic [CW-1:0] PL         = CW'(P_LAT);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2*N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N + P_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
`ifdef SPM_DRV_SELFCHECK_EN
    CHECK,
`endif
    DONE
  } state_t;

`ifdef SPM_DRV_SELFCHECK_EN
  localparam state_t AFTER_CAP = CHECK;
`else
  localparam state_t AFTER_CAP = DONE;
`endif

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N-1:0]            x_q, x_d;
  logic signed [N-1:0]     ysr_q, ysr_d;
  logic [2*N-1:0]          preg_q, preg_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    ysr_d     = ysr_q;
    preg_d    = preg_q;
    in_ready  = 1'b0;
    spm_clr   = 1'b0;
    spm_y     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_x;
          ysr_d   = in_y;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        spm_clr = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        spm_y = ysr_q[0];
        // Arithmetic shift keeps replicating the sign bit once y is exhausted.
        ysr_d = ysr_q >>> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= PL)
          preg_d = {spm_p, preg_q[2*N-1:1]};
        if (cnt_q == SHIFT_LAST)
          state_d = (P_LAT == 0) ? AFTER_CAP : DRAIN;
      end
      DRAIN: begin
        spm_y  = ysr_q[N-1];
        cnt_d  = cnt_q + 1'b1;
        preg_d = {spm_p, preg_q[2*N-1:1]};
        if (cnt_q == DRAIN_LAST)
          state_d = AFTER_CAP;
      end
`ifdef SPM_DRV_SELFCHECK_EN
      CHECK: begin
        state_d = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      ysr_q   <= '0;
      preg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      ysr_q   <= ysr_d;
      preg_q  <= preg_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign spm_x = x_q;
  assign out_p = preg_q;

`ifdef SPM_DRV_SELFCHECK_EN
  logic [N-1:0]          yl_q;
  logic signed [2*N-1:0] ref_q;
  logic                  err_q;
  logic signed [2*N-1:0] xe, ye;

  assign xe = {{N{x_q[N-1]}}, x_q};
  assign ye = {{N{yl_q[N-1]}}, yl_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yl_q  <= '0;
      ref_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid)
        yl_q <= in_y;
      ref_q <= xe * ye;
      // Sticky: one bad product flags the multiplier until the next reset.
      if (state_q == CHECK && preg_q != ref_q)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_spm_serial_driver.sv
// Scoreboarded bench for spm_serial_driver (N=8, P_LAT=1) with a behavioural spm model.
module tb_spm_serial_driver;
  localparam int N = 8;
  localparam int P_LAT = 1;
`ifdef SPM_DRV_SELFCHECK_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N-1:0] in_x = '0;
  logic [N-1:0] in_y = '0;
  logic [N-1:0] spm_x;
  logic spm_y, spm_clr;
  logic spm_p = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [2*N-1:0] out_p;
  logic busy;
`ifdef SPM_DRV_SELFCHECK_EN
  logic err;
`endif

  spm_serial_driver #(.N(N), .P_LAT(P_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .spm_x(spm_x), .spm_y(spm_y), .spm_clr(spm_clr), .spm_p(spm_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
`ifdef SPM_DRV_SELFCHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
    int             hs;
  } item_t;
  item_t sb[$];

  bit flip_b4 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [2*N:0] exp_y(input logic [N-1:0] y);
    logic signed [2*N-1:0] s;
    s = $signed(y);
    return {y[N-1], s};
  endfunction

  // Ideal spm: product bit k is bit k of the running sum of x*y_j*2^j, one cycle late.
  initial begin
    longint acc = 0;
    longint xs;
    int k = 0;
    logic nxt = 1'b0;
    forever begin
      @(negedge clk);
      if (spm_clr) begin
        acc = 0; k = 0; nxt = 1'b0;
      end else begin
        xs = longint'($signed(spm_x));
        if (spm_y) acc = acc + (xs <<< k);
        nxt = acc[k] ^ (flip_b4 && k == 4);
        if (k < 60) k++;
      end
      @(posedge clk);
      #1 spm_p = nxt;
    end
  end

  // Monitor: latency, clear width and spm_y stream on out_valid rise; product on handshake.
  initial begin
    bit prev_v = 1'b0;
    int clr_seen = 0;
    int idx = 0;
    logic [2*N:0] ycol = '0;
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst) begin
        clr_seen = 0; idx = 0; prev_v = 1'b0;
      end else begin
        if (spm_clr) begin
          clr_seen++; idx = 0;
        end else if (busy && idx < 2*N + P_LAT) begin
          ycol[idx] = spm_y; idx++;
        end
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) fail("unexpected_out_valid");
          else begin
            it = sb[0];
            chk("latency", cyc - it.hs, LAT);
            chk("clr_cycles", clr_seen, 1);
            chk("spm_y_seq", 32'(ycol), 32'(exp_y(it.y)));
          end
          clr_seen = 0;
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          it = sb.pop_front();
          chk("out_p", 32'(out_p), 32'(it.p));
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit hold,
                        input logic [2*N-1:0] pmask);
    item_t it;
    int xs, ys;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin fail("in_ready_timeout"); return; end
    xs = int'($signed(x));
    ys = int'($signed(y));
    it.x = x; it.y = y; it.hs = cyc;
    it.p = (2*N)'(xs * ys) ^ pmask;
    sb.push_back(it);
    in_valid = 1'b1; in_x = x; in_y = y;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (!hold) out_ready = ($urandom_range(0, 3) != 0);
      in_x = N'($urandom); in_y = N'($urandom);
      chk("spm_x_hold", 32'(spm_x), 32'(x));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold) begin
      for (int i = 0; i < 100 && !out_valid; i++) begin
        @(posedge clk); #1;
      end
      if (!out_valid) fail("out_valid_timeout");
      for (int i = 0; i < 10; i++) begin
        chk("bp_hold", {out_p, spm_x, in_ready, busy, out_valid},
            {it.p, x, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", {in_ready, out_valid, busy}, 3'b100);
    end else begin
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (sb.size() != 0) begin fail("result_timeout"); sb.delete(); end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] cx [6] = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
    logic [N-1:0] cy [6] = '{8'h80, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h80};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, busy, spm_x, in_ready, spm_clr, spm_y, out_p},
        {2'b00, 8'h00, 1'b1, 2'b00, 16'h0000});
    rst = 1'b1;

    run_op(8'd3, 8'd5, 1'b0, '0);
    run_op(8'hFD, 8'h07, 1'b0, '0);
    run_op(8'h7F, 8'h80, 1'b1, '0);
    for (int i = 0; i < 6; i++) run_op(cx[i], cy[i], 1'b0, '0);

    // Abort in the middle of the shift phase.
    for (int i = 0; i < 100 && !in_ready; i++) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_x = 8'd5; in_y = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("clr_pulse", 32'(spm_clr), 32'd1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_midop", {out_valid, busy, spm_x, in_ready, spm_clr, spm_y, out_p},
        {2'b00, 8'h00, 1'b1, 2'b00, 16'h0000});
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(8'd2, 8'hFF, 1'b0, '0);

    for (int i = 0; i < 20; i++) run_op(N'($urandom), N'($urandom), 1'b0, '0);

`ifdef SPM_DRV_SELFCHECK_EN
    chk("err_clean", 32'(err), 32'd0);
    flip_b4 = 1'b1;
    run_op(8'h35, 8'hC3, 1'b0, 16'h0010);
    flip_b4 = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    run_op(8'h11, 8'h22, 1'b0, '0);
    chk("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    chk("err_reset", 32'(err), 32'd0);
    run_op(8'h9A, 8'h5C, 1'b0, '0);
    chk("err_after_good", 32'(err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
